// File: rtl/decode_pipe_register.sv
// decode_pipe_register: DEPTH-stage elastic valid/ready pipe for the decode control word.
// Optional stall statistics counter enabled by the DECODE_PIPE_STALL_CNT_EN macro.
`default_nettype none

module decode_pipe_register #(
  parameter int                CTRL_W    = 17,
  parameter int                DEPTH     = 1,
  parameter logic [CTRL_W-1:0] NOP_VALUE = {CTRL_W{1'b0}}
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [CTRL_W-1:0] IN_DATA,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CTRL_W-1:0] OUT_DATA,
  output logic [3:0]        OCCUPANCY,
  output logic [15:0]       STALL_CNT
);

  logic [DEPTH-1:0]             v_q, v_d;
  logic [DEPTH-1:0][CTRL_W-1:0] d_q, d_d;
  logic [DEPTH-1:0]             load;
  logic [3:0]                   occ_q, occ_d;
  logic                         gap;

  // A stage can take new content when it or any stage downstream has room.
  always_comb begin
    load = '0;
    gap  = OUT_READY;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      gap     = gap | ~v_q[i];
      load[i] = gap;
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (load[0]) begin
      v_d[0] = IN_VALID;
      if (IN_VALID) d_d[0] = IN_DATA;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (load[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) d_d[i] = d_q[i-1];
      end
    end
    if (FLUSH) v_d = '0;
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) occ_d = occ_d + {3'b000, v_d[i]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v_q   <= '0;
      d_q   <= {DEPTH{NOP_VALUE}};
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end

  assign IN_READY  = ~RST & (FLUSH | load[0]);
  assign OUT_VALID = v_q[DEPTH-1];
  assign OUT_DATA  = v_q[DEPTH-1] ? d_q[DEPTH-1] : NOP_VALUE;
  assign OCCUPANCY = occ_q;

`ifdef DECODE_PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where a live word is held by execute.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (v_q[DEPTH-1] && !OUT_READY && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign STALL_CNT = stall_cnt_q;
`else
  assign STALL_CNT = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decode_pipe_register.sv
// Scoreboard bench for decode_pipe_register (DEPTH=3): directed scenarios plus random traffic.
`default_nettype none

module tb_decode_pipe_register;
  localparam int                CTRL_W = 17;
  localparam int                DEPTH  = 3;
  localparam logic [CTRL_W-1:0] NOP    = '0;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              IN_VALID = 1'b0;
  logic [CTRL_W-1:0] IN_DATA = '0;
  logic              FLUSH = 1'b0;
  logic              OUT_READY = 1'b0;
  logic              IN_READY;
  logic              OUT_VALID;
  logic [CTRL_W-1:0] OUT_DATA;
  logic [3:0]        OCCUPANCY;
  logic [15:0]       STALL_CNT;

  decode_pipe_register #(.CTRL_W(CTRL_W), .DEPTH(DEPTH), .NOP_VALUE(NOP)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OCCUPANCY(OCCUPANCY), .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: words in flight, oldest first, with their stage position.
  logic [CTRL_W-1:0] data_q[$];
  int                pos_q[$];
  int                stall_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, compares against the model, then advances the model
  // to what the upcoming rising edge should produce.
  always @(negedge CLK) begin
    logic              exp_v, exp_rdy, push;
    logic [CTRL_W-1:0] exp_d;
    int                ahead, stall_shown;
    if (RST) begin
      data_q.delete();
      pos_q.delete();
      stall_exp = 0;
    end
    exp_v   = (data_q.size() > 0) && (pos_q[0] == DEPTH - 1);
    exp_d   = exp_v ? data_q[0] : NOP;
    exp_rdy = !RST && (FLUSH || data_q.size() < DEPTH || OUT_READY);
`ifdef DECODE_PIPE_STALL_CNT_EN
    stall_shown = stall_exp;
`else
    stall_shown = 0;
`endif
    chk("out_valid", 32'(OUT_VALID), 32'(exp_v));
    chk("out_data", 32'(OUT_DATA), 32'(exp_d));
    chk("in_ready", 32'(IN_READY), 32'(exp_rdy));
    chk("occupancy", 32'(OCCUPANCY), 32'(data_q.size()));
    chk("stall_cnt", 32'(STALL_CNT), 32'(stall_shown));
    if (!RST) begin
      if (exp_v && !OUT_READY && stall_exp < 65535) stall_exp++;
      if (OUT_VALID && OUT_READY) begin
        if (data_q.size() == 0) begin
          chk("unexpected_pop", 32'(OUT_DATA), 32'(NOP));
        end else begin
          chk("pop_data", 32'(OUT_DATA), 32'(data_q[0]));
          void'(data_q.pop_front());
          void'(pos_q.pop_front());
        end
      end
      push = IN_VALID && exp_rdy && !FLUSH;
      if (FLUSH) begin
        data_q.delete();
        pos_q.delete();
      end else begin
        ahead = DEPTH;
        for (int k = 0; k < pos_q.size(); k++) begin
          pos_q[k] = (pos_q[k] + 1 < ahead - 1) ? pos_q[k] + 1 : ahead - 1;
          ahead    = pos_q[k];
        end
        if (push) begin
          data_q.push_back(IN_DATA);
          pos_q.push_back(0);
        end
      end
    end
  end

  task automatic step(input logic r, input logic iv, input logic [CTRL_W-1:0] d,
                      input logic fl, input logic ordy);
    @(posedge CLK);
    #1;
    RST = r; IN_VALID = iv; IN_DATA = d; FLUSH = fl; OUT_READY = ordy;
  endtask

  initial begin
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Streaming with no backpressure
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, CTRL_W'(i), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)  step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Backpressure: fill, hold, release
    step(1'b0, 1'b1, 17'h0000A, 1'b0, 1'b0);
    step(1'b0, 1'b1, 17'h0000B, 1'b0, 1'b0);
    step(1'b0, 1'b1, 17'h0000C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 17'h0000D, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Flush over a full pipe with a simultaneous input word
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, CTRL_W'(17'h100 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 17'h0001F, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Continuous push and pop at full occupancy
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, CTRL_W'(17'h200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, CTRL_W'(17'h300 + i), 1'b0, 1'b1);

    // Asynchronous reset in the middle of a cycle while words are in flight
    @(posedge CLK);
    #3;
    RST = 1'b1;
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), CTRL_W'($urandom),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

`ifdef DECODE_PIPE_STALL_CNT_EN
    // Counter saturation; a following flush must not clear it
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, CTRL_W'(17'h400 + i), 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
`endif

    @(posedge CLK);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
